// File: rtl/riscv_mc_main_control.sv
// Main control FSM for the multicycle RISC-V CPU: decodes the opcode into per-cycle
// datapath strobes and mux selects, stalls on mem_ready, and counts retired instructions.
module riscv_mc_main_control #(
    parameter logic [6:0]  OPC_LOAD   = 7'b0000011,
    parameter logic [6:0]  OPC_STORE  = 7'b0100011,
    parameter logic [6:0]  OPC_RTYPE  = 7'b0110011,
    parameter logic [6:0]  OPC_ITYPE  = 7'b0010011,
    parameter logic [6:0]  OPC_BRANCH = 7'b1100011,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_en,
    output logic             branch,
    output logic             adr_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_o
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9
    } state_t;

    state_t state;
    state_t state_next;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                    state_next = S_MEMADR;
                end else if (opcode == OPC_RTYPE) begin
                    state_next = S_EXECR;
                end else if (opcode == OPC_ITYPE) begin
                    state_next = S_EXECI;
                end else if (opcode == OPC_BRANCH) begin
                    state_next = S_BEQ;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMADR: begin
                if (opcode == OPC_LOAD) begin
                    state_next = S_MEMREAD;
                end else if (opcode == OPC_STORE) begin
                    state_next = S_MEMWRITE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // Moore output decode; reset forces every strobe and select low
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b01;
                    illegal_op = !(opcode == OPC_LOAD || opcode == OPC_STORE ||
                                   opcode == OPC_RTYPE || opcode == OPC_ITYPE ||
                                   opcode == OPC_BRANCH);
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    adr_src  = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src    = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                S_EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a  = 2'b10;
                    alu_op     = 2'b01;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
        pc_en = pc_write | (branch & zero);
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
        end else if (instr_done) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_riscv_mc_main_control.sv
// Directed bench for riscv_mc_main_control: walks each instruction class cycle by cycle
// against hand-derived state sequences and strobe values.
module tb_riscv_mc_main_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_en, branch, adr_src, mem_read, mem_write;
    logic        ir_write, reg_write, illegal_op, instr_done;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
    logic [31:0] instr_count;
    logic [3:0]  state_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_count = 32'd0;

    riscv_mc_main_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_en(pc_en), .branch(branch), .adr_src(adr_src),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op),
        .instr_done(instr_done), .instr_count(instr_count), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011; zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({pc_write, pc_en, branch, mem_read, mem_write, ir_write, reg_write,
                 illegal_op, instr_done} !== 9'b0) begin
                errors++;
                $display("FAIL reset_strobes cyc%0d: got %b want 0", i,
                    {pc_write, pc_en, branch, mem_read, mem_write, ir_write, reg_write,
                     illegal_op, instr_done});
            end
            checks++;
            if ({adr_src, result_src, alu_src_a, alu_src_b, alu_op} !== 9'b0) begin
                errors++;
                $display("FAIL reset_selects cyc%0d: got %b want 0", i,
                    {adr_src, result_src, alu_src_a, alu_src_b, alu_op});
            end
            checks++;
            if (state_o !== 4'd0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: got %0d want 0", i, state_o);
            end
        end
        checks++;
        if (instr_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", instr_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({state_o, ir_write, pc_write, pc_en, alu_src_b} !== {4'd0, 1'b1, 1'b1, 1'b1, 2'b10}) begin
            errors++;
            $display("FAIL post_reset_fetch: got st=%0d ir=%b pcw=%b pce=%b b=%b want st=0 ir=1 pcw=1 pce=1 b=10",
                state_o, ir_write, pc_write, pc_en, alu_src_b);
        end
        exp_count = 32'd0;
    endtask

    task automatic test_rtype();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
        opcode = 7'b0110011; mem_ready = 1'b1; zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state_o !== exp_st[i]) begin
                errors++;
                $display("FAIL rtype_state cyc%0d: got %0d want %0d", i, state_o, exp_st[i]);
            end
            checks++;
            if ({alu_op, reg_write, instr_done} !==
                {(i == 2) ? 2'b10 : 2'b00, i == 3, i == 3}) begin
                errors++;
                $display("FAIL rtype_ctrl cyc%0d: got aluop=%b rw=%b done=%b", i, alu_op, reg_write, instr_done);
            end
            tick();
        end
        exp_count = exp_count + 32'd1;
        checks++;
        if (instr_count !== exp_count || state_o !== 4'd0) begin
            errors++;
            $display("FAIL rtype_count: got cnt=%0d st=%0d want cnt=%0d st=0", instr_count, state_o, exp_count);
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic       rdy    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 7'b0000011; zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state_o !== exp_st[i]) begin
                errors++;
                $display("FAIL lw_state cyc%0d: got %0d want %0d", i, state_o, exp_st[i]);
            end
            checks++;
            if ({mem_read, adr_src, reg_write, instr_done} !==
                {exp_st[i] == 4'd0 || exp_st[i] == 4'd3, exp_st[i] == 4'd3, i == 7, i == 7}) begin
                errors++;
                $display("FAIL lw_ctrl cyc%0d: got mr=%b adr=%b rw=%b done=%b", i, mem_read, adr_src, reg_write, instr_done);
            end
            if (i == 7) begin
                checks++;
                if (result_src !== 2'b01) begin
                    errors++;
                    $display("FAIL lw_result_src: got %b want 01", result_src);
                end
            end
            tick();
        end
        exp_count = exp_count + 32'd1;
        checks++;
        if (instr_count !== exp_count || state_o !== 4'd0) begin
            errors++;
            $display("FAIL lw_count: got cnt=%0d st=%0d want cnt=%0d st=0", instr_count, state_o, exp_count);
        end
    endtask

    task automatic test_sw();
        logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
        logic       rdy    [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        opcode = 7'b0100011; zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state_o !== exp_st[i]) begin
                errors++;
                $display("FAIL sw_state cyc%0d: got %0d want %0d", i, state_o, exp_st[i]);
            end
            checks++;
            if ({mem_write, adr_src, reg_write, instr_done} !== {i >= 3, i >= 3, 1'b0, i == 5}) begin
                errors++;
                $display("FAIL sw_ctrl cyc%0d: got mw=%b adr=%b rw=%b done=%b", i, mem_write, adr_src, reg_write, instr_done);
            end
            tick();
        end
        exp_count = exp_count + 32'd1;
        checks++;
        if (instr_count !== exp_count || state_o !== 4'd0) begin
            errors++;
            $display("FAIL sw_count: got cnt=%0d st=%0d want cnt=%0d st=0", instr_count, state_o, exp_count);
        end
    endtask

    task automatic test_beq(input logic z);
        logic [3:0] exp_st [3] = '{4'd0, 4'd1, 4'd9};
        opcode = 7'b1100011; mem_ready = 1'b1; zero = z;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state_o !== exp_st[i]) begin
                errors++;
                $display("FAIL beq_state z=%b cyc%0d: got %0d want %0d", z, i, state_o, exp_st[i]);
            end
            checks++;
            if ({pc_en, branch, alu_op, instr_done} !==
                {(i == 0) | ((i == 2) & z), i == 2, (i == 2) ? 2'b01 : 2'b00, i == 2}) begin
                errors++;
                $display("FAIL beq_ctrl z=%b cyc%0d: got pce=%b br=%b aluop=%b done=%b",
                    z, i, pc_en, branch, alu_op, instr_done);
            end
            tick();
        end
        exp_count = exp_count + 32'd1;
        checks++;
        if (instr_count !== exp_count) begin
            errors++;
            $display("FAIL beq_count z=%b: got %0d want %0d", z, instr_count, exp_count);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] exp_st [3] = '{4'd0, 4'd1, 4'd0};
        opcode = 7'b1111111; mem_ready = 1'b1; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({state_o, illegal_op, instr_done} !== {exp_st[i], i == 1, 1'b0}) begin
                errors++;
                $display("FAIL illegal cyc%0d: got st=%0d ill=%b done=%b want st=%0d ill=%b done=0",
                    i, state_o, illegal_op, instr_done, exp_st[i], i == 1);
            end
            if (i < 2) tick();
        end
        checks++;
        if (instr_count !== exp_count) begin
            errors++;
            $display("FAIL illegal_count: got %0d want %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_reset_midop();
        opcode = 7'b0100011; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state_o, mem_write} !== {4'd5, 1'b1}) begin
            errors++;
            $display("FAIL midop_pre: got st=%0d mw=%b want st=5 mw=1", state_o, mem_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0) begin
            errors++;
            $display("FAIL midop_mw_drop: got %b want 0", mem_write);
        end
        tick();
        checks++;
        if ({state_o, instr_count} !== {4'd0, 32'd0}) begin
            errors++;
            $display("FAIL midop_after: got st=%0d cnt=%0d want st=0 cnt=0", state_o, instr_count);
        end
        reset = 1'b0;
        exp_count = 32'd0;
    endtask

    initial begin
        reset = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw();
        test_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_mc_main_control.md
Name: riscv_mc_main_control

Overview:
- Main control FSM for the multicycle RISC-V CPU.
- Decodes the 7-bit opcode into per-cycle datapath strobes and mux selects.
- Produces the 2-bit ALUOp that feeds the downstream ALU control decoder: 00 = add, 01 = subtract/compare, 10 = decode using funct fields.
- Sits between the instruction register and the datapath. Supports lw, sw, R-type, addi (I-type ALU) and beq. Stalls on a memory-ready handshake.

Parameters:
- OPC_LOAD, 7'b0000011, lw opcode
- OPC_STORE, 7'b0100011, sw opcode
- OPC_RTYPE, 7'b0110011, R-type opcode
- OPC_ITYPE, 7'b0010011, I-type ALU opcode (treated as add-immediate)
- OPC_BRANCH, 7'b1100011, beq opcode
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instruction register bits [6:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC update
- pc_en  out  1  final PC enable = pc_write | (branch & zero)
- branch  out  1  conditional branch cycle
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write
- result_src  out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1 register
- alu_src_b  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4
- alu_op  out  2  to ALU control decoder
- illegal_op  out  1  one-cycle pulse: unsupported opcode in DECODE
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- instr_count  out  CNT_W  retired-instruction counter
- state_o  out  4  current state, for debug

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset.
- On any rising edge with reset=1: state <= FETCH, instr_count <= 0.
- While reset=1, all strobes are forced to 0 combinationally, including mid-operation: pc_write, pc_en, branch, mem_read, mem_write, ir_write, reg_write, illegal_op, instr_done. Selects and alu_op are 0 during reset.
- Outputs are decoded from state (Moore). The only exceptions are the mem_ready/zero/opcode gating noted below.
- Unlisted outputs are 0 in each state.
- States and encodings:
  - FETCH=0: adr_src=0, mem_read=1, a=00, b=10, alu_op=00, result_src=10. ir_write and pc_write equal mem_ready. If mem_ready then next = DECODE, else hold.
  - DECODE=1: a=01, b=01, alu_op=00 (branch target into ALUOut).
    - Next state: LOAD/STORE -> MEMADR, RTYPE -> EXECR, ITYPE -> EXECI, BRANCH -> BEQ.
    - Any other opcode -> FETCH with illegal_op=1 that cycle. No count increment.
  - MEMADR=2: a=10, b=01, alu_op=00. Next: lw -> MEMREAD, sw -> MEMWRITE. The opcode is stable from the IR.
  - MEMREAD=3: adr_src=1, mem_read=1, result_src=00. Hold until mem_ready, then MEMWB.
  - MEMWB=4: result_src=01, reg_write=1, instr_done=1. Next = FETCH.
  - MEMWRITE=5: adr_src=1, mem_write=1, result_src=00.
    - mem_write stays high every cycle until mem_ready.
    - Then instr_done=1 that cycle and next = FETCH.
  - EXECR=6: a=10, b=00, alu_op=10. Next = ALUWB.
  - EXECI=7: a=10, b=01, alu_op=00. Next = ALUWB.
  - ALUWB=8: result_src=00, reg_write=1, instr_done=1. Next = FETCH.
  - BEQ=9: a=10, b=00, alu_op=01, result_src=00, branch=1, instr_done=1. Next = FETCH.
  - Codes 10-15: next = FETCH, all strobes 0.
- pc_en = pc_write | (branch & zero), combinational.
- instr_count increments by 1 on every edge where instr_done=1. It wraps modulo 2^CNT_W.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Latency with mem_ready=1 throughout: R/I-type 4 cycles, lw 5, sw 4, beq 3, illegal 2.

Test Plan:
- Reset held 2 cycles with mem_ready=1, opcode=0110011 -> all strobes 0 and state_o=0 during reset. First post-reset cycle is FETCH with ir_write=1, pc_write=1, alu_src_b=10.
- R-type 0110011 with mem_ready=1 -> states 0,1,6,8. alu_op=10 only in state 6. reg_write=1 only in state 8. instr_done one pulse. instr_count=1.
- lw 0000011 with mem_ready=0 for the first 3 MEMREAD cycles -> MEMREAD held 4 cycles, then MEMWB with result_src=01, reg_write=1. Total 8 cycles.
- sw 0100011 with mem_ready low 2 cycles -> mem_write=1 for 3 consecutive cycles and adr_src=1. reg_write never asserted.
- beq 1100011 run twice, zero=1 then zero=0 -> pc_en=1 in BEQ the first time, 0 the second. alu_op=01 in both.
- opcode 1111111 -> FETCH, DECODE, FETCH with illegal_op pulse in DECODE and instr_count unchanged. Separately, assert reset during MEMWRITE -> mem_write drops in the same cycle and state_o=0 after the edge.
